offchip_link_tx: RTL and testbench
==================================

// Module: offchip_link_tx
// PURPOSE
//  Upstream (transmit) end of the off-chip token-credit link. Accepts 64-bit core words and
//  serialises each one over NUM_CH parallel narrow channels, lowest byte first.
//  Credits are consumed per word and restored by toggle tokens returned by the downstream
//  receiver's channel 0. Sits between the core and the pad-side io_* wires.
// PARAMETERS
//  CORE_WIDTH  64  core word width; must equal NUM_CH*CH_WIDTH*BEATS
//  NUM_CH      2   number of parallel link channels
//  CH_WIDTH    8   bits per channel per beat
//  CREDITS     4   receiver buffer capacity in core words; the initial credit count
//  (derived) BEATS = CORE_WIDTH/(NUM_CH*CH_WIDTH) = 4; SLICE = CORE_WIDTH/NUM_CH = 32
// PORTS
//  clk              in   1                  clock
//  rst              in   1                  reset, synchronous, active-high
//  core_valid_in    in   1                  core word valid
//  core_data_in     in   CORE_WIDTH         core word
//  core_ready_out   out  1                  word accepted when valid_in && ready_out
//  io_valid_out     out  1                  beat valid on all channels
//  io_data_out      out  NUM_CH*CH_WIDTH    channel c at bits [c*CH_WIDTH +: CH_WIDTH]
//  io_token_in      in   1                  toggle token; each level change returns 1 credit
//  credit_cnt_out   out  $clog2(CREDITS+1)  current credit count
//  credit_err_out   out  1                  sticky: token received while credits == CREDITS
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, beat=0, credits=CREDITS, tok_q=0, word register=0
//   - io_valid_out=0, io_data_out=0, credit_err_out=0
//   - core_ready_out=1 (combinational)
//  FSM IDLE/SEND:
//   - core_ready_out = (credits != 0) && (state==IDLE || (state==SEND && beat==BEATS-1)).
//   - Accept: latch word, credits-1, beat=0, state=SEND.
//   - SEND, every cycle: io_valid_out=1; channel c outputs word[c*SLICE + beat*CH_WIDTH +: CH_WIDTH].
//   - SEND, beat==BEATS-1: if an accept occurs in the same cycle, stay in SEND with beat=0.
//     Otherwise go to IDLE; io_valid_out=0 and io_data_out holds its last value.
//  Latency: io_data_out/io_valid_out are registered. A word accepted at the edge ending
//   cycle T drives beat 0 in T+1. Back-to-back words sustain 1 word per BEATS cycles (no gap).
//  Token path:
//   - edge = io_token_in ^ tok_q; tok_q <= io_token_in every cycle.
//   - Each edge adds 1 credit.
//  Simultaneous accept + edge: credits unchanged.
//  Overflow: edge arriving at credits==CREDITS with no accept in the same cycle:
//   - credits stay at CREDITS (saturate); credit_err_out set.
//   - credit_err_out clears only on rst.
//  Credits==0: core_ready_out=0. The beat in flight still completes; no further words are accepted.
//  Reset mid-word: remaining beats are dropped; io_valid_out is 0 in the cycle after rst.
//  core_data_in is sampled only on accept; later changes do not affect the word in flight.
// CONFIGURATION
//  OFFCHIP_TX_PARITY_EN defined:
//   - adds output io_parity_out [NUM_CH-1:0]; bit c = ~^(channel c beat), i.e. odd parity.
//   - registered and aligned with io_data_out; resets to {NUM_CH{1'b1}}.
//   - held with the data when idle.
//  Not defined: the port and its logic are absent; behaviour is otherwise identical.
// TESTING
//  T1 reset: assert rst 2 cycles ->
//   - io_valid_out=0, io_data_out=0, credit_cnt_out=4, core_ready_out=1, credit_err_out=0.
//  T2 single word 64'h8877665544332211 ->
//   - beats 1..4: ch0=11,22,33,44 and ch1=55,66,77,88; io_valid_out=1 for exactly 4 cycles.
//   - credit_cnt_out goes 4->3.
//  T3 five words, core_valid held high, no tokens ->
//   - words 1-4 stream gap-free (16 valid cycles); credit_cnt_out reaches 0.
//   - core_ready_out=0; word 5 is stalled.
//  T4 from T3, toggle io_token_in once ->
//   - credit_cnt_out=1 the cycle after; word 5 is accepted; its beat 0 appears one cycle later.
//  T5 token edge in the same cycle as an accept at credits=2 -> credit_cnt_out stays 2.
//  T6 idle at credits=4, toggle io_token_in ->
//   - credit_cnt_out stays 4; credit_err_out=1 and stays 1 until rst.
//   - Also: rst during beat 2 -> no beats 3/4 are emitted.
//   - Parity build: byte 8'h07 -> io_parity_out bit=0.

Source files
------------

// File: rtl/offchip_link_tx.sv
// ---------------------------------------------------------------------------
// offchip_link_tx
// Transmit end of the off-chip token-credit link. Each 64-bit core word is
// serialised over NUM_CH parallel narrow channels, lowest byte of each
// channel slice first. One credit is consumed per accepted word, and one is
// restored for every level change seen on io_token_in.
//
// Ports
//   clk             clock
//   rst             synchronous, active-high reset
//   core_valid_in   core word valid
//   core_data_in    core word (sampled only when accepted)
//   core_ready_out  word accepted when core_valid_in && core_ready_out
//   io_valid_out    beat valid on all channels (registered)
//   io_data_out     channel c at bits [c*CH_WIDTH +: CH_WIDTH] (registered)
//   io_token_in     toggle token from the receiver; each level change = 1 credit
//   credit_cnt_out  current credit count
//   credit_err_out  sticky: token received while credits were already full
//   io_parity_out   (OFFCHIP_TX_PARITY_EN only) odd parity per channel beat
//
// Build option
//   OFFCHIP_TX_PARITY_EN  adds io_parity_out; undefined builds omit it.
// ---------------------------------------------------------------------------
module offchip_link_tx #(
  parameter int CORE_WIDTH = 64,
  parameter int NUM_CH     = 2,
  parameter int CH_WIDTH   = 8,
  parameter int CREDITS    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           core_valid_in,
  input  logic [CORE_WIDTH-1:0]          core_data_in,
  output logic                           core_ready_out,
  output logic                           io_valid_out,
  output logic [NUM_CH*CH_WIDTH-1:0]     io_data_out,
  input  logic                           io_token_in,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt_out,
  output logic                           credit_err_out
`ifdef OFFCHIP_TX_PARITY_EN
  ,
  output logic [NUM_CH-1:0]              io_parity_out
`endif
);

  localparam int BEATS  = CORE_WIDTH / (NUM_CH * CH_WIDTH);
  localparam int SLICE  = CORE_WIDTH / NUM_CH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(CREDITS + 1);
  localparam int IO_W   = NUM_CH * CH_WIDTH;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [CORE_WIDTH-1:0]   word_q;
  logic [CNT_W-1:0]        credits_q, credits_d;
  logic                    tok_q;
  logic                    err_set;
  logic                    last_beat;
  logic                    accept;
  logic                    tok_edge;
  logic                    load_beat;
  logic                    io_valid_d;
  logic [IO_W-1:0]         io_data_d;
  logic [CORE_WIDTH-1:0]   src_word;

  // Handshake: a new word may be taken when idle or while the final beat of
  // the current word is on the wire, which gives gap-free back-to-back words.
  always_comb begin
    last_beat      = (state_q == SEND) && (beat_q == BEAT_W'(BEATS - 1));
    core_ready_out = (credits_q != '0) && ((state_q == IDLE) || last_beat);
    accept         = core_valid_in && core_ready_out;
    tok_edge       = io_token_in ^ tok_q;
  end

  // Next-state and next-beat selection. On accept the beat 0 slice is taken
  // straight from core_data_in so it reaches the pads one cycle later.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    io_valid_d = 1'b0;
    load_beat  = 1'b0;
    if (accept) begin
      state_d    = SEND;
      beat_d     = '0;
      io_valid_d = 1'b1;
      load_beat  = 1'b1;
    end else begin
      case (state_q)
        SEND: begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d     = beat_q + BEAT_W'(1);
            io_valid_d = 1'b1;
            load_beat  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Channel c carries its own SLICE-wide part of the word, one CH_WIDTH
  // chunk per beat. When no beat is loaded the pads hold their last value.
  always_comb begin
    src_word  = accept ? core_data_in : word_q;
    io_data_d = io_data_out;
    if (load_beat) begin
      for (int c = 0; c < NUM_CH; c++) begin
        io_data_d[c*CH_WIDTH +: CH_WIDTH] =
          src_word[c*SLICE + int'(beat_d)*CH_WIDTH +: CH_WIDTH];
      end
    end
  end

  // Credit bookkeeping. An accept and a token edge together cancel out.
  // A token arriving while full saturates and raises the sticky error.
  always_comb begin
    credits_d = credits_q;
    err_set   = 1'b0;
    if (accept && !tok_edge) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (!accept && tok_edge) begin
      if (credits_q == CNT_W'(CREDITS)) begin
        err_set = 1'b1;
      end else begin
        credits_d = credits_q + CNT_W'(1);
      end
    end
  end

  // State, word, credit and pad registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      word_q         <= '0;
      credits_q      <= CNT_W'(CREDITS);
      tok_q          <= 1'b0;
      credit_err_out <= 1'b0;
      io_valid_out   <= 1'b0;
      io_data_out    <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      credits_q    <= credits_d;
      tok_q        <= io_token_in;
      io_valid_out <= io_valid_d;
      io_data_out  <= io_data_d;
      if (accept) begin
        word_q <= core_data_in;
      end
      if (err_set) begin
        credit_err_out <= 1'b1;
      end
    end
  end

  assign credit_cnt_out = credits_q;

`ifdef OFFCHIP_TX_PARITY_EN
  logic [NUM_CH-1:0] parity_d;

  // Odd parity of each channel beat, derived from the same next-data value
  // so it stays aligned with io_data_out and holds with it when idle.
  always_comb begin
    parity_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      parity_d[c] = ~^io_data_d[c*CH_WIDTH +: CH_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_parity_out <= {NUM_CH{1'b1}};
    end else begin
      io_parity_out <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_offchip_link_tx.sv
// ---------------------------------------------------------------------------
// tb_offchip_link_tx
// Self-checking bench for offchip_link_tx. A transaction-level reference
// model (credit counter plus a queue of beats still owed to the pads) is
// stepped once per clock alongside the DUT; every cycle the DUT outputs are
// compared with the model via immediate assertions.
// ---------------------------------------------------------------------------
module tb_offchip_link_tx;

  localparam int CORE_WIDTH = 64;
  localparam int NUM_CH     = 2;
  localparam int CH_WIDTH   = 8;
  localparam int CREDITS    = 4;
  localparam int BEATS      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_valid_in;
  logic [63:0] core_data_in;
  logic        core_ready_out;
  logic        io_valid_out;
  logic [15:0] io_data_out;
  logic        io_token_in;
  logic [2:0]  credit_cnt_out;
  logic        credit_err_out;
`ifdef OFFCHIP_TX_PARITY_EN
  logic [1:0]  io_parity_out;
`endif

  offchip_link_tx #(
    .CORE_WIDTH(CORE_WIDTH),
    .NUM_CH    (NUM_CH),
    .CH_WIDTH  (CH_WIDTH),
    .CREDITS   (CREDITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_valid_in (core_valid_in),
    .core_data_in  (core_data_in),
    .core_ready_out(core_ready_out),
    .io_valid_out  (io_valid_out),
    .io_data_out   (io_data_out),
    .io_token_in   (io_token_in),
    .credit_cnt_out(credit_cnt_out),
    .credit_err_out(credit_err_out)
`ifdef OFFCHIP_TX_PARITY_EN
    ,
    .io_parity_out (io_parity_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: what the pads show now, the beats still owed,
  // the credit count, sticky error and last seen token level.
  int          m_credits;
  bit          m_err;
  bit          m_valid;
  logic [15:0] m_data;
  logic [15:0] m_pending[$];
  bit          m_tok;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;
  bit cur_tok = 1'b0;
  bit toggled;

  // Beat b of a word: channel 0 takes byte b of the low half, channel 1
  // takes byte b of the high half.
  function automatic logic [15:0] beat_of(input logic [63:0] w, input int b);
    logic [63:0] lo;
    logic [63:0] hi;
    lo = (w >> (8 * b)) & 64'hFF;
    hi = (w >> (32 + 8 * b)) & 64'hFF;
    return {hi[7:0], lo[7:0]};
  endfunction

  function automatic bit model_ready();
    return (m_credits != 0) && (m_pending.size() == 0);
  endfunction

  task automatic model_reset();
    m_credits = CREDITS;
    m_err     = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_tok     = 1'b0;
    m_pending.delete();
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput(input string tag);
    checkValue({tag, ".ready"},  64'(core_ready_out), 64'(model_ready()));
    checkValue({tag, ".valid"},  64'(io_valid_out),   64'(m_valid));
    checkValue({tag, ".data"},   64'(io_data_out),    64'(m_data));
    checkValue({tag, ".credit"}, 64'(credit_cnt_out), 64'(m_credits));
    checkValue({tag, ".err"},    64'(credit_err_out), 64'(m_err));
`ifdef OFFCHIP_TX_PARITY_EN
    checkValue({tag, ".parity"}, 64'(io_parity_out),
               64'({~^m_data[15:8], ~^m_data[7:0]}));
`endif
  endtask

  // Drive one cycle of inputs, check outputs, then advance the model across
  // the following rising edge.
  task automatic applyStimulus(input string tag, input bit r, input bit v,
                               input logic [63:0] d, input bit t);
    bit acc;
    bit tedge;
    @(negedge clk);
    rst           = r;
    core_valid_in = v;
    core_data_in  = d;
    io_token_in   = t;
    #1;
    if (check_en) checkOutput(tag);
    if (r) begin
      model_reset();
    end else begin
      acc   = v && model_ready();
      tedge = (t != m_tok);
      m_tok = t;
      if (acc) begin
        for (int b = 0; b < BEATS; b++) m_pending.push_back(beat_of(d, b));
      end
      if (m_pending.size() > 0) begin
        m_data  = m_pending.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (acc && !tedge) begin
        m_credits--;
      end else if (!acc && tedge) begin
        if (m_credits == CREDITS) m_err = 1'b1;
        else m_credits++;
      end
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst           = 1'b1;
    core_valid_in = 1'b0;
    core_data_in  = '0;
    io_token_in   = 1'b0;
    model_reset();

    // Reset for two cycles; outputs are defined from the second cycle on.
    applyStimulus("rst", 1'b1, 1'b0, 64'h0, cur_tok);
    check_en = 1'b1;
    applyStimulus("rst", 1'b1, 1'b0, 64'h0, cur_tok);
    applyStimulus("reset_state", 1'b0, 1'b0, 64'h0, cur_tok);

    // Single word, then idle long enough to see all four beats and the drop.
    applyStimulus("single", 1'b0, 1'b1, 64'h8877665544332211, cur_tok);
    for (int i = 0; i < 6; i++)
      applyStimulus("single", 1'b0, 1'b0, rand64(), cur_tok);

    // Fresh credits, then valid held high with no tokens: four words stream,
    // credits drain to zero and the fifth word stalls.
    applyStimulus("rst", 1'b1, 1'b0, 64'h0, cur_tok);
    for (int i = 0; i < 24; i++)
      applyStimulus("stream", 1'b0, 1'b1, rand64(), cur_tok);

    // One token returns one credit and lets the stalled word through.
    cur_tok = ~cur_tok;
    applyStimulus("token", 1'b0, 1'b1, rand64(), cur_tok);
    for (int i = 0; i < 8; i++)
      applyStimulus("token", 1'b0, 1'b1, rand64(), cur_tok);

    // Token edge coinciding with an accept at credits=2 leaves credits at 2.
    applyStimulus("rst", 1'b1, 1'b0, 64'h0, cur_tok);
    toggled = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!toggled && m_credits == 2 && model_ready()) begin
        cur_tok = ~cur_tok;
        toggled = 1'b1;
      end
      applyStimulus("accept_tok", 1'b0, 1'b1, rand64(), cur_tok);
    end

    // Token while idle and full: credits saturate, error becomes sticky.
    applyStimulus("rst", 1'b1, 1'b0, 64'h0, cur_tok);
    applyStimulus("overflow", 1'b0, 1'b0, 64'h0, cur_tok);
    applyStimulus("overflow", 1'b0, 1'b0, 64'h0, cur_tok);
    cur_tok = ~cur_tok;
    applyStimulus("overflow", 1'b0, 1'b0, 64'h0, cur_tok);
    for (int i = 0; i < 4; i++)
      applyStimulus("overflow", 1'b0, 1'b0, 64'h0, cur_tok);

    // Reset mid-word: remaining beats never appear, error clears.
    applyStimulus("rst", 1'b1, 1'b0, 64'h0, cur_tok);
    applyStimulus("midrst", 1'b0, 1'b1, rand64(), cur_tok);
    applyStimulus("midrst", 1'b0, 1'b0, 64'h0, cur_tok);
    applyStimulus("midrst", 1'b1, 1'b0, 64'h0, cur_tok);
    for (int i = 0; i < 5; i++)
      applyStimulus("midrst", 1'b0, 1'b0, 64'h0, cur_tok);

    // Word whose first channel-0 byte is 8'h07 (odd parity bit 0).
    applyStimulus("byte07", 1'b0, 1'b1, 64'h000000F0_00000007, cur_tok);
    for (int i = 0; i < 5; i++)
      applyStimulus("byte07", 1'b0, 1'b0, 64'h0, cur_tok);

    // Randomized traffic: bursty valid, random data, random token toggles,
    // occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 15) cur_tok = ~cur_tok;
      applyStimulus("random", ($urandom_range(99) == 0), ($urandom_range(99) < 70),
                    rand64(), cur_tok);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
